mod_n_counter: RTL and testbench

- Parametrised modulo-N counter for the digital clock datapath. It supersedes the fixed 1-bit toggle counter.
- Adds count enable, up/down direction, synchronous parallel load, a terminal-count output for cascading, and a registered wrap pulse.
- Instances chain as seconds-units (N=10), seconds-tens (N=6), minutes and hours stages, with each stage's tc driving the next stage's en.

---
 rtl/clock_pkg.sv | 19 +
 rtl/mod_n_next.sv | 31 +++
 rtl/mod_n_counter.sv | 95 +++++++++
 tb/tb_mod_n_counter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the digital clock counter datapath.
// Consumed by mod_n_next and mod_n_counter.
package clock_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int SEC_UNITS_MOD = 10;
    localparam int SEC_TENS_MOD  = 6;
    localparam int MIN_UNITS_MOD = 10;
    localparam int MIN_TENS_MOD  = 6;
    localparam int HOUR_MOD      = 24;

    // Smallest count width able to hold 0..modulus-1.
    function automatic int min_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-count logic for a modulo-N up/down counter.
// Reports whether the current count sits at the terminal value for the direction.
module mod_n_next
    import clock_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_val,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        next_val = count;
        at_term  = 1'b0;
        if (up_dn == DIR_UP) begin
            at_term  = (count == MAX_VAL);
            next_val = at_term ? '0 : count + WIDTH'(1);
        end else begin
            at_term  = (count == '0);
            next_val = at_term ? MAX_VAL : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N counter stage with enable, direction, load, cascade tc and wrap pulse.
// Defining MOD_COUNTER_SYNC_CLR_EN adds the synchronous clear input sclr.
module mod_n_counter
    import clock_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk1,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_SYNC_CLR_EN
    input  logic             sclr,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (MODULUS < 2 || MODULUS > 65536) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS %0d outside 2..65536", MODULUS);
    end
    if (WIDTH < min_width(MODULUS)) begin : g_bad_width
        $error("mod_n_counter: WIDTH %0d too narrow for MODULUS %0d", WIDTH, MODULUS);
    end

    // One extra bit so MODULUS itself is representable for the range check.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next_val;
    logic             at_term;
    logic             load_ok;
    logic             sclr_act;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             load_err_d;

`ifdef MOD_COUNTER_SYNC_CLR_EN
    assign sclr_act = sclr;
`else
    assign sclr_act = 1'b0;
`endif

    mod_n_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .count    (count),
        .up_dn    (up_dn),
        .next_val (next_val),
        .at_term  (at_term)
    );

    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // A load or clear in progress must never step the next stage.
    assign tc = en & ~load & ~sclr_act & at_term;

    always_comb begin
        count_d    = count;
        wrap_d     = 1'b0;
        load_err_d = load_err;
        if (sclr_act) begin
            count_d = '0;
        end else if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            count_d = next_val;
            wrap_d  = at_term;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk1 or posedge clr) begin
        if (clr) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_d;
            wrap     <= wrap_d;
            load_err <= load_err_d;
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter: reset, wrap in both directions,
// loads, load/enable collision, and a 10 -> 6 cascade.
module tb_mod_n_counter;

    logic clk1 = 1'b0;
    logic clr  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk1 = ~clk1;

    // Stage A: MODULUS 10
    logic       en_a = 0, up_a = 1, load_a = 0;
    logic [3:0] lv_a = '0;
    logic [3:0] count_a;
    logic       tc_a, wrap_a, err_a;
    // Stage B: MODULUS 6
    logic       en_b = 0, up_b = 1, load_b = 0;
    logic [2:0] lv_b = '0;
    logic [2:0] count_b;
    logic       tc_b, wrap_b, err_b;
    // Cascade: C1 (10) drives C2 (6)
    logic       en_c = 0;
    logic [3:0] count_c1;
    logic [2:0] count_c2;
    logic       tc_c1, wrap_c1, err_c1, tc_c2, wrap_c2, err_c2;
`ifdef MOD_COUNTER_SYNC_CLR_EN
    logic       sclr_a = 0;
`endif

    mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_dut_a (
        .clk1(clk1), .clr(clr), .en(en_a), .up_dn(up_a), .load(load_a), .load_val(lv_a),
`ifdef MOD_COUNTER_SYNC_CLR_EN
        .sclr(sclr_a),
`endif
        .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
    );

    mod_n_counter #(.MODULUS(6), .WIDTH(3)) u_dut_b (
        .clk1(clk1), .clr(clr), .en(en_b), .up_dn(up_b), .load(load_b), .load_val(lv_b),
`ifdef MOD_COUNTER_SYNC_CLR_EN
        .sclr(1'b0),
`endif
        .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
    );

    mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_sec_units (
        .clk1(clk1), .clr(clr), .en(en_c), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
`ifdef MOD_COUNTER_SYNC_CLR_EN
        .sclr(1'b0),
`endif
        .count(count_c1), .tc(tc_c1), .wrap(wrap_c1), .load_err(err_c1)
    );

    mod_n_counter #(.MODULUS(6), .WIDTH(3)) u_sec_tens (
        .clk1(clk1), .clr(clr), .en(tc_c1), .up_dn(1'b1), .load(1'b0), .load_val(3'd0),
`ifdef MOD_COUNTER_SYNC_CLR_EN
        .sclr(1'b0),
`endif
        .count(count_c2), .tc(tc_c2), .wrap(wrap_c2), .load_err(err_c2)
    );

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_clr();
        #2 clr = 1'b1;
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0 || err_a !== 1'b0 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d wrap=%b err=%b tc=%b, need 0 0 0 0",
                     count_a, wrap_a, err_a, tc_a);
        end
        // Illegal load then legal load to 7, then async clear between edges.
        load_a = 1; lv_a = 4'd12;
        step();
        lv_a = 4'd7;
        step();
        load_a = 0;
        checks++;
        if (count_a !== 4'd7 || err_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: count=%0d err=%b, need 7 1", count_a, err_a);
        end
        #2 clr = 1'b1;
        #1;
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d wrap=%b err=%b, need 0 0 0",
                     count_a, wrap_a, err_a);
        end
        clr = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_cnt [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic [3:0] prev;
        pulse_clr();
        en_a = 1; up_a = 1; load_a = 0;
        prev = 4'd0;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (tc_a !== (prev == 4'd9)) begin
                errors++;
                $display("FAIL up_tc[%0d]: tc=%b at count %0d", i, tc_a, prev);
            end
            step();
            checks++;
            if (count_a !== exp_cnt[i] || wrap_a !== (i == 9)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: count=%0d wrap=%b, need %0d %b",
                         i, count_a, wrap_a, exp_cnt[i], (i == 9));
            end
            prev = exp_cnt[i];
        end
        en_a = 0;
    endtask

    task automatic test_down_wrap();
        logic [2:0] exp_cnt [8] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4};
        logic [2:0] prev;
        pulse_clr();
        en_b = 1; up_b = 0; load_b = 0;
        prev = 3'd0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (tc_b !== (prev == 3'd0)) begin
                errors++;
                $display("FAIL down_tc[%0d]: tc=%b at count %0d", i, tc_b, prev);
            end
            step();
            checks++;
            if (count_b !== exp_cnt[i] || wrap_b !== (i == 0 || i == 6)) begin
                errors++;
                $display("FAIL down_wrap[%0d]: count=%0d wrap=%b, need %0d %b",
                         i, count_b, wrap_b, exp_cnt[i], (i == 0 || i == 6));
            end
            prev = exp_cnt[i];
        end
        en_b = 0;
    endtask

    task automatic test_load();
        logic [2:0] exp_cnt [3] = '{3'd5, 3'd0, 3'd1};
        pulse_clr();
        en_b = 0; up_b = 1;
        load_b = 1; lv_b = 3'd4;
        step();
        checks++;
        if (count_b !== 3'd4 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL load_legal: count=%0d err=%b, need 4 0", count_b, err_b);
        end
        lv_b = 3'd7;
        step();
        load_b = 0;
        checks++;
        if (count_b !== 3'd4 || err_b !== 1'b1 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL load_illegal: count=%0d err=%b wrap=%b, need 4 1 0",
                     count_b, err_b, wrap_b);
        end
        en_b = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count_b !== exp_cnt[i] || err_b !== 1'b1) begin
                errors++;
                $display("FAIL load_err_sticky[%0d]: count=%0d err=%b, need %0d 1",
                         i, count_b, err_b, exp_cnt[i]);
            end
        end
        en_b = 0;
        pulse_clr();
        #1;
        checks++;
        if (err_b !== 1'b0) begin
            errors++;
            $display("FAIL load_err_clear: err=%b, need 0", err_b);
        end
    endtask

    task automatic test_collision();
        pulse_clr();
        en_a = 0; up_a = 1;
        load_a = 1; lv_a = 4'd9;
        step();
        load_a = 0;
        #1;
        checks++;
        if (count_a !== 4'd9 || tc_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_tc: count=%0d tc=%b, need 9 0", count_a, tc_a);
        end
        step();
        checks++;
        if (count_a !== 4'd9 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL hold: count=%0d wrap=%b, need 9 0", count_a, wrap_a);
        end
        en_a = 1; load_a = 1; lv_a = 4'd3;
        #1;
        checks++;
        if (tc_a !== 1'b0) begin
            errors++;
            $display("FAIL collide_tc: tc=%b, need 0", tc_a);
        end
        step();
        checks++;
        if (count_a !== 4'd3 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL collide: count=%0d wrap=%b, need 3 0", count_a, wrap_a);
        end
        load_a = 0; en_a = 0;
    endtask

    task automatic test_cascade();
        int wraps1 = 0;
        int wraps2 = 0;
        pulse_clr();
        en_c = 1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (wrap_c1 === 1'b1) wraps1++;
            if (wrap_c2 === 1'b1) wraps2++;
            if (i == 15) begin
                checks++;
                if (count_c1 !== 4'd5 || count_c2 !== 3'd1) begin
                    errors++;
                    $display("FAIL cascade_mid: units=%0d tens=%0d, need 5 1", count_c1, count_c2);
                end
            end
        end
        en_c = 0;
        #1;
        checks++;
        if (count_c1 !== 4'd0 || count_c2 !== 3'd0 || wraps1 != 6 || wraps2 != 1) begin
            errors++;
            $display("FAIL cascade_end: units=%0d tens=%0d wraps=%0d/%0d, need 0 0 6/1",
                     count_c1, count_c2, wraps1, wraps2);
        end
        checks++;
        if (tc_c1 !== 1'b0 || tc_c2 !== 1'b0 || err_c1 !== 1'b0 || err_c2 !== 1'b0) begin
            errors++;
            $display("FAIL cascade_idle: tc=%b/%b err=%b/%b, need 0", tc_c1, tc_c2, err_c1, err_c2);
        end
    endtask

`ifdef MOD_COUNTER_SYNC_CLR_EN
    task automatic test_sclr();
        pulse_clr();
        load_a = 1; lv_a = 4'd9;
        step();
        load_a = 0; en_a = 1; up_a = 1; sclr_a = 1;
        #1;
        checks++;
        if (tc_a !== 1'b0) begin
            errors++;
            $display("FAIL sclr_tc: tc=%b, need 0", tc_a);
        end
        step();
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL sclr_clear: count=%0d wrap=%b, need 0 0", count_a, wrap_a);
        end
        sclr_a = 0;
        for (int i = 0; i < 5; i++) step();
        sclr_a = 1; en_a = 0;
        step();
        sclr_a = 0;
        checks++;
        if (count_a !== 4'd0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL sclr_at5: count=%0d err=%b, need 0 0", count_a, err_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_collision();
        test_cascade();
`ifdef MOD_COUNTER_SYNC_CLR_EN
        test_sclr();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
